mem_boot_loader: RTL and testbench
==================================

Name: mem_boot_loader

Overview:
- Parametrised successor to the CPU top-level external-write path. It streams a program/data image into data or instruction memory over a valid/ready handshake, with auto-incrementing addresses and a word count.
- Holds the CPU in reset for the whole load and releases it after a programmable delay.
- After release it passes the CPU memory port straight through.
- Supports reload at run time: a new ld_start re-asserts CPU reset.

Parameters:
DATA_W, 32, memory data width in bits (multiple of 8)
ADDR_W, 32, memory byte-address width
CNT_W, 16, width of word count / words-loaded counter
RELEASE_DLY, 4, cycles spent in RELEASE before cpu_rst_n rises (>=1)
WORD_STORE, 3'b010, store-size code driven on mem_store during loader writes

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
ld_start  input  1  start-load pulse, sampled on clk
ld_base  input  ADDR_W  first byte address of image, sampled with ld_start
ld_count  input  CNT_W  number of words to load, sampled with ld_start
ld_valid  input  1  loader word valid
ld_data  input  DATA_W  loader word
ld_ready  output  1  loader may transfer this cycle
cpu_mem_we  input  1  CPU store enable
cpu_addr  input  ADDR_W  CPU data address
cpu_wdata  input  DATA_W  CPU store data
cpu_store  input  3  CPU store-size code
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_store  output  3  memory store-size code
cpu_rst_n  output  1  CPU reset, active-low, registered
ld_busy  output  1  high in LOAD or RELEASE
ld_done  output  1  sticky; high once an image has completed, cleared by next ld_start accept
ld_words  output  CNT_W  words written in current/last load

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN.
- Reset (reset=0, async): state=IDLE, cpu_rst_n=0, ld_done=0, ld_words=0, address and count registers 0, release counter 0.
- IDLE:
  - ld_start=1 with ld_count!=0 -> LOAD. Latch addr_reg = ld_base with low log2(DATA_W/8) bits forced to 0; latch rem = ld_count; ld_words=0; ld_done=0.
  - ld_start=1 with ld_count=0 -> RELEASE directly; ld_done=1.
- LOAD: ld_ready=1 (combinational from state). A transfer occurs when ld_valid & ld_ready. In that same cycle:
  - mem_we=1, mem_addr=addr_reg, mem_wdata=ld_data, mem_store=WORD_STORE.
  - Next cycle: addr_reg += DATA_W/8, wrapping modulo 2^ADDR_W; rem -= 1; ld_words += 1.
  - Transfer with rem=1 -> RELEASE, ld_done=1.
  - No transfer: mem_we=0, state holds; no timeout.
- RELEASE: ld_ready=0, mem_we=0. Counter runs 0..RELEASE_DLY-1, then -> RUN.
- RUN: mem_we/mem_addr/mem_wdata/mem_store = cpu_mem_we/cpu_addr/cpu_wdata/cpu_store; ld_ready=0.
- cpu_rst_n is a register that equals (state==RUN). It rises on the first RUN cycle edge and falls on the edge after leaving RUN.
- ld_start:
  - ignored in LOAD and RELEASE.
  - in RUN, accepted exactly as in IDLE (reload); the CPU port is disconnected from the next cycle.
- Outside RUN, CPU inputs are ignored. Outside LOAD, ld_valid is ignored (no write, ld_ready=0).
- mem_addr outside RUN and outside a transfer = addr_reg; mem_wdata=0; mem_store=WORD_STORE.
- Asserting reset mid-LOAD aborts immediately. Memory writes already done persist; state returns to IDLE.

Test Plan:
- Reset then ld_start, ld_base=0x100, ld_count=3, words 0xA,0xB,0xC back-to-back -> writes to 0x100,0x104,0x108. ld_done=1, ld_words=3. cpu_rst_n rises RELEASE_DLY+1 cycles after last write.
- Same load with ld_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, each only on valid cycles, addresses unchanged from above.
- ld_base=0xFFFFFFFC, ld_count=2 -> writes at 0xFFFFFFFC then 0x00000000. Unaligned ld_base=0x103 -> first write at 0x100.
- ld_count=0 -> no mem_we ever, ld_done=1, RUN after RELEASE_DLY cycles.
- In RUN, CPU store cpu_addr=0x20, cpu_wdata=0x55, cpu_store=3'b000 -> mirrored on mem_* same cycle. Then ld_start with count=1 -> cpu_rst_n=0 next cycle, CPU writes blocked, ld_done clears.
- reset=0 after 2 of 5 words -> ld_ready=0 and cpu_rst_n=0 immediately. After release: IDLE, ld_words=0, no further writes.

Source files
------------

// File: rtl/mem_boot_loader.sv
// Boot loader: streams an image into memory over a valid/ready port while holding
// the CPU in reset, then releases the CPU and passes its memory port through.
module mem_boot_loader #(
    parameter int         DATA_W      = 32,
    parameter int         ADDR_W      = 32,
    parameter int         CNT_W       = 16,
    parameter int         RELEASE_DLY = 4,
    parameter logic [2:0] WORD_STORE  = 3'b010
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [CNT_W-1:0]  ld_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              cpu_mem_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_store,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_store,
    output logic              cpu_rst_n,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [CNT_W-1:0]  ld_words,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam int                BYTES      = DATA_W / 8;
    localparam int                RW         = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BYTES);
    localparam logic [RW-1:0]     REL_LAST   = RW'(RELEASE_DLY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              done_q, done_d;
    logic [RW-1:0]     rel_q, rel_d;
    logic              cpu_rst_n_q;
    logic              xfer;

    // Handshake: a word moves on any cycle where ld_valid and ld_ready are both high;
    // ld_ready depends only on state, never on ld_valid.
    assign ld_ready = (state_q == LOAD);
    assign xfer     = ld_ready && ld_valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        words_d = words_q;
        done_d  = done_q;
        rel_d   = rel_q;
        case (state_q)
            IDLE, RUN: begin
                if (ld_start) begin
                    words_d = '0;
                    if (ld_count != '0) begin
                        state_d = LOAD;
                        addr_d  = ld_base & ALIGN_MASK;
                        rem_d   = ld_count;
                        done_d  = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        done_d  = 1'b1;
                        rel_d   = '0;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    addr_d  = addr_q + STRIDE;
                    rem_d   = rem_q - CNT_W'(1);
                    words_d = words_q + CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = RELEASE;
                        done_d  = 1'b1;
                        rel_d   = '0;
                    end
                end
            end
            RELEASE: begin
                if (rel_q == REL_LAST) begin
                    state_d = RUN;
                    rel_d   = '0;
                end else begin
                    rel_d = rel_q + RW'(1);
                end
            end
            default: ;
        endcase
    end

    // cpu_rst_n is registered from the next state so it tracks (state == RUN) exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            words_q     <= '0;
            done_q      <= 1'b0;
            rel_q       <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            words_q     <= words_d;
            done_q      <= done_d;
            rel_q       <= rel_d;
            cpu_rst_n_q <= (state_d == RUN);
        end
    end

    always_comb begin
        if (state_q == RUN) begin
            mem_we    = cpu_mem_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_store = cpu_store;
        end else begin
            mem_we    = xfer;
            mem_addr  = addr_q;
            mem_wdata = xfer ? ld_data : '0;
            mem_store = WORD_STORE;
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign ld_busy   = (state_q == LOAD) || (state_q == RELEASE);
    assign ld_done   = done_q;
    assign ld_words  = words_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: randomized image loads checked against an expected
// write queue and the release timing derived from the load rules.
module tb_mem_boot_loader;

    localparam int         DATA_W      = 32;
    localparam int         ADDR_W      = 32;
    localparam int         CNT_W       = 16;
    localparam int         RELEASE_DLY = 4;
    localparam logic [2:0] WORD_STORE  = 3'b010;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ld_start = 1'b0;
    logic [ADDR_W-1:0] ld_base = '0;
    logic [CNT_W-1:0]  ld_count = '0;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_ready;
    logic              cpu_mem_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [2:0]        cpu_store = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_store;
    logic              cpu_rst_n;
    logic              ld_busy;
    logic              ld_done;
    logic [CNT_W-1:0]  ld_words;
    logic [1:0]        dbg_state;

    mem_boot_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .RELEASE_DLY(RELEASE_DLY), .WORD_STORE(WORD_STORE)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_mem_we(cpu_mem_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_store(cpu_store),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_store(mem_store), .cpu_rst_n(cpu_rst_n), .ld_busy(ld_busy),
        .ld_done(ld_done), .ld_words(ld_words), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0]        data_q[$];
    bit                       cpu_test = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every loader write seen on the memory port must be the next expected one.
    always @(negedge clk) begin
        if (!cpu_test && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[ADDR_W+DATA_W-1:DATA_W]);
                check("wr_data", mem_wdata, e[DATA_W-1:0]);
                check("wr_store", mem_store, WORD_STORE);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after ld_start is sampled.
    task automatic start_load(input logic [ADDR_W-1:0] base, input int n, input bit seq);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] w;
        data_q.delete();
        for (int i = 0; i < n; i++) begin
            w = seq ? DATA_W'(32'hA + i) : DATA_W'($urandom);
            a = (base & 32'hFFFF_FFFC) + ADDR_W'(4 * i);
            data_q.push_back(w);
            exp_q.push_back({a, w});
        end
        ld_start = 1'b1;
        ld_base  = base;
        ld_count = CNT_W'(n);
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        ld_base  = ADDR_W'($urandom);
        ld_count = CNT_W'($urandom);
    endtask

    task automatic feed(input int lim, input int pct, input logic [15:0] pat, input int patlen);
        int sent = 0;
        int cyc = 0;
        bit v;
        while (sent < lim && cyc < 500) begin
            v = (patlen > 0) ? pat[cyc % patlen] : ($urandom_range(99) < pct);
            ld_valid = v;
            ld_data  = v ? data_q[sent] : DATA_W'($urandom);
            @(negedge clk);
            check("ld_ready_load", ld_ready, 1);
            check("cpu_rst_load", cpu_rst_n, 0);
            @(posedge clk);
            #1;
            if (v) sent++;
            cyc++;
        end
        ld_valid = 1'($urandom_range(1));
        ld_data  = DATA_W'($urandom);
        if (cyc >= 500) check("feed_timeout", sent, lim);
        check("exp_q_left", exp_q.size(), data_q.size() - sent);
    endtask

    // Measures cycles from the entering-RELEASE edge until cpu_rst_n rises.
    task automatic wait_run(input int n_words);
        int k = 0;
        @(negedge clk);
        check("done_set", ld_done, 1);
        if (n_words >= 0) check("ld_words", ld_words, n_words);
        check("ready_release", ld_ready, 0);
        check("busy_release", ld_busy, 1);
        check("wdata_idle", mem_wdata, 0);
        while (cpu_rst_n !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("release_delay", k, RELEASE_DLY);
        check("busy_run", ld_busy, 0);
        check("ready_run", ld_ready, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_ld_done", ld_done, 0);
        check("rst_ld_words", ld_words, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_mem_we", mem_we, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back load of 0xA,0xB,0xC at 0x100.
        start_load(32'h100, 3, 1'b1);
        feed(3, 100, 16'h0, 0);
        wait_run(3);

        // Same image with valid toggling 1,0,0,1,0,1.
        start_load(32'h100, 3, 1'b1);
        feed(3, 0, 16'b0000_0000_0010_1001, 6);
        wait_run(3);

        // Address wrap and unaligned base.
        start_load(32'hFFFF_FFFC, 2, 1'b0);
        feed(2, 70, 16'h0, 0);
        wait_run(2);
        start_load(32'h103, 3, 1'b0);
        feed(3, 60, 16'h0, 0);
        wait_run(3);

        // Empty image goes straight to release with no writes.
        start_load(32'h400, 0, 1'b0);
        wait_run(-1);

        // CPU passthrough in RUN, then reload cuts the CPU off.
        cpu_test   = 1'b1;
        ld_valid   = 1'b0;
        cpu_mem_we = 1'b1;
        cpu_addr   = 32'h20;
        cpu_wdata  = 32'h55;
        cpu_store  = 3'b000;
        #1;
        check("cpu_we", mem_we, 1);
        check("cpu_addr", mem_addr, 32'h20);
        check("cpu_wdata", mem_wdata, 32'h55);
        check("cpu_store", mem_store, 3'b000);
        for (int i = 0; i < 4; i++) begin
            cpu_mem_we = 1'($urandom_range(1));
            cpu_addr   = ADDR_W'($urandom);
            cpu_wdata  = DATA_W'($urandom);
            cpu_store  = 3'($urandom_range(7));
            @(negedge clk);
            check("cpu_rnd_we", mem_we, cpu_mem_we);
            check("cpu_rnd_addr", mem_addr, cpu_addr);
            check("cpu_rnd_wdata", mem_wdata, cpu_wdata);
            check("cpu_rnd_store", mem_store, cpu_store);
            @(posedge clk);
            #1;
        end
        cpu_mem_we = 1'b1;
        start_load(32'h200, 1, 1'b0);
        #1;
        check("reload_cpu_rst_n", cpu_rst_n, 0);
        check("reload_cpu_blocked", mem_we, 0);
        check("reload_done_clear", ld_done, 0);
        check("reload_ready", ld_ready, 1);
        check("reload_addr", mem_addr, 32'h200);
        check("reload_store", mem_store, WORD_STORE);
        cpu_mem_we = 1'b0;
        cpu_test   = 1'b0;
        feed(1, 100, 16'h0, 0);
        wait_run(1);

        // Random reloads from RUN.
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, 8);
            start_load(ADDR_W'($urandom), n, 1'b0);
            feed(n, $urandom_range(30, 100), 16'h0, 0);
            wait_run(n);
        end

        // Reset in the middle of a 5-word load.
        start_load(32'h300, 5, 1'b0);
        feed(2, 100, 16'h0, 0);
        ld_valid = 1'b1;
        ld_data  = data_q[2];
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("abort_ready", ld_ready, 0);
        check("abort_cpu_rst_n", cpu_rst_n, 0);
        check("abort_busy", ld_busy, 0);
        check("abort_words", ld_words, 0);
        check("abort_mem_we", mem_we, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_abort_ready", ld_ready, 0);
            check("post_abort_words", ld_words, 0);
            check("post_abort_cpu_rst_n", cpu_rst_n, 0);
        end
        ld_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
